mult_datapath: RTL and testbench

Register-and-arithmetic datapath for the 8-bit signed shift-add multiplier; it sits directly downstream of the multiplier control FSM and executes that FSM's one-hot-ish `load`/`shift`/`add`/`sub` commands. It holds the accumulator A, the multiplier register B and the sign-extension bit X, and performs 9-bit signed add/subtract of the switch operand S into X:A. It returns B[0] to the FSM as `M` and drives the product {A,B} to the display logic.

---
 rtl/mult_datapath.sv | 118 +++++++++++
 tb/tb_mult_datapath.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// Accumulator (A), multiplier (B) and sign bit (X) registers plus a shared 9-bit add/sub for the signed shift-add multiplier.
// Define MULT_DP_DONE_CNT_EN to build the shift counter that drives done; otherwise done is tied low.
module mult_datapath #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         load,
    input  logic         clr_ax,
    input  logic         add,
    input  logic         sub,
    input  logic         shift,
    input  logic [W-1:0] S,
    output logic [W-1:0] Aval,
    output logic [W-1:0] Bval,
    output logic         X,
    output logic         M,
    output logic         done
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         x_q, x_d;
    logic [W:0]   opnd_s;
    logic [W:0]   sum_s;
    logic         cin_s;

    // Single adder: subtraction inverts the sign-extended operand and injects carry-in.
    always_comb begin
        opnd_s = {S[W-1], S};
        cin_s  = 1'b0;
        if (sub) begin
            opnd_s = ~{S[W-1], S};
            cin_s  = 1'b1;
        end else begin
            opnd_s = {S[W-1], S};
            cin_s  = 1'b0;
        end
        sum_s = {a_q[W-1], a_q} + opnd_s + {{W{1'b0}}, cin_s};
    end

    // Next-state selection in fixed priority: load > clr_ax > sub > add > shift.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        if (load) begin
            a_d = {W{1'b0}};
            x_d = 1'b0;
            b_d = S;
        end else if (clr_ax) begin
            a_d = {W{1'b0}};
            x_d = 1'b0;
        end else if (sub || add) begin
            x_d = sum_s[W];
            a_d = sum_s[W-1:0];
        end else if (shift) begin
            a_d = {x_q, a_q[W-1:1]};
            b_d = {a_q[0], b_q[W-1:1]};
        end else begin
            a_d = a_q;
        end
    end

    // Datapath state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q <= {W{1'b0}};
            b_q <= {W{1'b0}};
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

`ifdef MULT_DP_DONE_CNT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    // Shift counter: cleared by load/clr_ax, counts only executed shifts, saturates at 8.
    always_comb begin
        cnt_d = cnt_q;
        if (load || clr_ax) begin
            cnt_d = 4'd0;
        end else if (sub || add) begin
            cnt_d = cnt_q;
        end else if (shift && (cnt_q != 4'd8)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        done_d = (cnt_d == 4'd8);
    end

    // Counter and registered done flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: vector table, full signed multiplies, reset and counter sequences.
module tb_mult_datapath;

    logic       Clk;
    logic       Reset_n;
    logic       load, clr_ax, add, sub, shift;
    logic [7:0] S;
    logic [7:0] Aval, Bval;
    logic       X, M, done;

    int checks;
    int errors;

    mult_datapath #(.W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .load(load), .clr_ax(clr_ax), .add(add), .sub(sub), .shift(shift),
        .S(S), .Aval(Aval), .Bval(Bval), .X(X), .M(M), .done(done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state
    logic [7:0] ma, mb;
    logic       mx;
    int         mcnt;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
        logic       d;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       l, c, ad, sb, sh;
        logic [7:0] s;
        logic [7:0] ea, eb;
        logic       ex;
    } vec_t;
    vec_t vecs[13];

    function automatic logic exp_done();
`ifdef MULT_DP_DONE_CNT_EN
        return (mcnt == 8);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ma = 8'h00; mb = 8'h00; mx = 1'b0; mcnt = 0;
    endtask

    task automatic model_apply(input logic l, c, ad, sb, sh, input logic [7:0] sv);
        int t;
        logic [8:0]  r;
        logic [16:0] p;
        if (l) begin
            ma = 8'h00; mx = 1'b0; mb = sv; mcnt = 0;
        end else if (c) begin
            ma = 8'h00; mx = 1'b0; mcnt = 0;
        end else if (sb || ad) begin
            t = sb ? ($signed(ma) - $signed(sv)) : ($signed(ma) + $signed(sv));
            r = t[8:0];
            mx = r[8]; ma = r[7:0];
        end else if (sh) begin
            p = {mx, ma, mb};
            p = {mx, p[16:1]};
            ma = p[15:8]; mb = p[7:0];
            if (mcnt < 8) mcnt = mcnt + 1;
        end
    endtask

    // One clock: drive strobes, push expected state, then pop and compare after the edge.
    task automatic step(input logic l, c, ad, sb, sh, input logic [7:0] sv);
        exp_t e;
        @(negedge Clk);
        load = l; clr_ax = c; add = ad; sub = sb; shift = sh; S = sv;
        model_apply(l, c, ad, sb, sh, sv);
        e.a = ma; e.b = mb; e.x = mx; e.d = exp_done();
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        check("sb_A", {8'h00, Aval}, {8'h00, e.a});
        check("sb_B", {8'h00, Bval}, {8'h00, e.b});
        check("sb_X", {15'h0, X}, {15'h0, e.x});
        check("sb_M", {15'h0, M}, {15'h0, e.b[0]});
        check("sb_done", {15'h0, done}, {15'h0, e.d});
    endtask

    task automatic run_mult(input logic [7:0] mplier, input logic [7:0] mcand,
                            input logic [15:0] exp_p, input logic exp_x);
        logic d_exp;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mplier);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mcand);
        for (int i = 0; i < 8; i++) begin
            if (mb[0]) step(1'b0, 1'b0, i < 7, i == 7, 1'b0, mcand);
            else       step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mcand);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mcand);
        end
`ifdef MULT_DP_DONE_CNT_EN
        d_exp = 1'b1;
`else
        d_exp = 1'b0;
`endif
        check("mult_product", {Aval, Bval}, exp_p);
        check("mult_X", {15'h0, X}, {15'h0, exp_x});
        check("mult_done", {15'h0, done}, {15'h0, d_exp});
    endtask

    initial begin
        logic d8;
        checks = 0; errors = 0;
        load = 1'b0; clr_ax = 1'b0; add = 1'b0; sub = 1'b0; shift = 1'b0; S = 8'h00;
        Reset_n = 1'b0;
        model_reset();

        //             l     c     add   sub   sh    S      A      B      X
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h00, 8'h12, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 8'h12, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h84, 8'h12, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h42, 8'h09, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h42, 8'h00, 8'h09, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'hFF, 8'h09, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h84, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'hFF, 8'h84, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 8'h84, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 8'h84, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 8'h84, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 8'h84, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h40, 8'h42, 1'b0};

        #12;
        check("reset_A", {8'h00, Aval}, 16'h0000);
        check("reset_B", {8'h00, Bval}, 16'h0000);
        check("reset_XMdone", {13'h0, X, M, done}, 16'h0000);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].l, vecs[i].c, vecs[i].ad, vecs[i].sb, vecs[i].sh, vecs[i].s);
            check($sformatf("vec%0d_A", i), {8'h00, Aval}, {8'h00, vecs[i].ea});
            check($sformatf("vec%0d_B", i), {8'h00, Bval}, {8'h00, vecs[i].eb});
            check($sformatf("vec%0d_X", i), {15'h0, X}, {15'h0, vecs[i].ex});
        end

        run_mult(8'h07, 8'h3B, 16'h019D, 1'b0);
        run_mult(8'hF9, 8'h3B, 16'hFE63, 1'b1);
        run_mult(8'h80, 8'h80, 16'h4000, 1'b0);

        // Counter: nine shifts after clr_ax, done rises after the 8th and holds.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef MULT_DP_DONE_CNT_EN
            d8 = (i >= 7);
`else
            d8 = 1'b0;
`endif
            check($sformatf("cnt_done%0d", i), {15'h0, done}, {15'h0, d8});
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("clr_done", {15'h0, done}, 16'h0000);

        // Asynchronous reset mid-cycle with A=0x55 and B loaded.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        check("pre_reset_A", {8'h00, Aval}, 16'h0055);
        load = 1'b0; add = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_A", {8'h00, Aval}, 16'h0000);
        check("async_B", {8'h00, Bval}, 16'h0000);
        check("async_XMdone", {13'h0, X, M, done}, 16'h0000);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        run_mult(8'h05, 8'hFD, 16'hFFF1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
